alu_seq_6502: RTL and testbench

ALU_SEQ_6502 -- requirements
Module: alu_seq_6502

---
 rtl/alu_seq_6502.sv | 168 ++++++++++++++++
 tb/tb_alu_seq_6502.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_6502.sv
// alu_seq_6502: sequencer for an external combinational 8-bit ALU.
// It accepts one command at a time, runs one ALU pass (three for SUB,
// which builds the two's complement of the operand first), updates the
// accumulator and N/Z/V flags, then returns the result over a
// valid/ready handshake.
module alu_seq_6502 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_op,
   input  logic [7:0] cmd_operand,
   output logic       result_valid,
   input  logic       result_ready,
   output logic [7:0] result_data,
   output logic       flag_n,
   output logic       flag_z,
   output logic       flag_v,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [4:0] alu_ctrl,
   input  logic [7:0] alu_out,
   input  logic       alu_v
);

   localparam logic [2:0] OP_LDA = 3'd0;
   localparam logic [2:0] OP_ADD = 3'd1;
   localparam logic [2:0] OP_SUB = 3'd2;
   localparam logic [2:0] OP_ORA = 3'd3;
   localparam logic [2:0] OP_EOR = 3'd4;
   localparam logic [2:0] OP_AND = 3'd5;
   localparam logic [2:0] OP_LSR = 3'd6;
   localparam logic [2:0] OP_CLV = 3'd7;

   // One-hot ALU function select {SUM,OR,XOR,AND,SR}
   localparam logic [4:0] CTRL_NONE = 5'b00000;
   localparam logic [4:0] CTRL_SUM  = 5'b10000;
   localparam logic [4:0] CTRL_OR   = 5'b01000;
   localparam logic [4:0] CTRL_XOR  = 5'b00100;
   localparam logic [4:0] CTRL_AND  = 5'b00010;
   localparam logic [4:0] CTRL_SR   = 5'b00001;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      NEG  = 3'd1,
      INC  = 3'd2,
      EXEC = 3'd3,
      RESP = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] op_q, op_d;
   logic [7:0] opnd_q, opnd_d;
   logic [7:0] tmp_q, tmp_d;
   logic [7:0] acc_q, acc_d;
   logic       n_q, n_d;
   logic       z_q, z_d;
   logic       v_q, v_d;
   // Registered so it stays low while reset is held and rises on the
   // first edge after release.
   logic       cmd_ready_q, cmd_ready_d;

   assign cmd_ready    = cmd_ready_q;
   assign result_valid = (state_q == RESP);
   assign result_data  = acc_q;
   assign flag_n       = n_q;
   assign flag_z       = z_q;
   assign flag_v       = v_q;

   // Next-state, datapath updates and ALU operand/function selection
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      opnd_d   = opnd_q;
      tmp_d    = tmp_q;
      acc_d    = acc_q;
      n_d      = n_q;
      z_d      = z_q;
      v_d      = v_q;
      alu_ctrl = CTRL_NONE;
      alu_a    = 8'h00;
      alu_b    = 8'h00;
      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               op_d   = cmd_op;
               opnd_d = cmd_operand;
               case (cmd_op)
                  OP_SUB:  state_d = NEG;
                  OP_CLV: begin
                     // CLV needs no ALU pass: clear V and respond directly
                     v_d     = 1'b0;
                     state_d = RESP;
                  end
                  default: state_d = EXEC;
               endcase
            end
         end
         NEG: begin
            // ones' complement of the operand
            alu_ctrl = CTRL_XOR;
            alu_a    = opnd_q;
            alu_b    = 8'hFF;
            tmp_d    = alu_out;
            state_d  = INC;
         end
         INC: begin
            // +1 completes the two's complement
            alu_ctrl = CTRL_SUM;
            alu_a    = tmp_q;
            alu_b    = 8'h01;
            tmp_d    = alu_out;
            state_d  = EXEC;
         end
         EXEC: begin
            alu_a = (op_q == OP_LDA) ? 8'h00 : acc_q;
            alu_b = (op_q == OP_SUB) ? tmp_q : opnd_q;
            case (op_q)
               OP_ADD, OP_SUB: alu_ctrl = CTRL_SUM;
               OP_LDA, OP_ORA: alu_ctrl = CTRL_OR;
               OP_EOR:         alu_ctrl = CTRL_XOR;
               OP_AND:         alu_ctrl = CTRL_AND;
               OP_LSR:         alu_ctrl = CTRL_SR;
               default:        alu_ctrl = CTRL_NONE;
            endcase
            acc_d = alu_out;
            n_d   = alu_out[7];
            z_d   = (alu_out == 8'h00);
            // V comes only from this pass; the negate passes never touch it
            if (op_q == OP_ADD || op_q == OP_SUB)
               v_d = alu_v;
            state_d = RESP;
         end
         RESP: begin
            if (result_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      cmd_ready_d = (state_d == IDLE);
   end

   // State and datapath registers; synchronous reset aborts any command
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= 3'd0;
         opnd_q      <= 8'h00;
         tmp_q       <= 8'h00;
         acc_q       <= 8'h00;
         n_q         <= 1'b0;
         z_q         <= 1'b0;
         v_q         <= 1'b0;
         cmd_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         opnd_q      <= opnd_d;
         tmp_q       <= tmp_d;
         acc_q       <= acc_d;
         n_q         <= n_d;
         z_q         <= z_d;
         v_q         <= v_d;
         cmd_ready_q <= cmd_ready_d;
      end
   end

endmodule

// File: tb/tb_alu_seq_6502.sv
// tb_alu_seq_6502: directed vector table plus hand-written sequences for
// response backpressure, reset abort and reset-vs-handshake priority.
module tb_alu_seq_6502;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [7:0] cmd_operand;
   logic       result_valid;
   logic       result_ready;
   logic [7:0] result_data;
   logic       flag_n, flag_z, flag_v;
   logic [7:0] alu_a, alu_b;
   logic [4:0] alu_ctrl;
   logic [7:0] alu_out;
   logic       alu_v;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_seq_6502 dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_operand(cmd_operand),
      .result_valid(result_valid), .result_ready(result_ready),
      .result_data(result_data),
      .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_out(alu_out), .alu_v(alu_v)
   );

   // Reference combinational ALU attached to the sequencer
   logic [7:0] sum8;
   assign sum8 = alu_a + alu_b;
   always_comb begin
      alu_out = 8'h00;
      alu_v   = 1'b0;
      case (alu_ctrl)
         5'b10000: begin
            alu_out = sum8;
            alu_v   = (alu_a[7] == alu_b[7]) && (sum8[7] != alu_a[7]);
         end
         5'b01000: alu_out = alu_a | alu_b;
         5'b00100: alu_out = alu_a ^ alu_b;
         5'b00010: alu_out = alu_a & alu_b;
         5'b00001: alu_out = (alu_b >= 8'd8) ? 8'h00 : (alu_a >> alu_b[2:0]);
         default:  alu_out = 8'h00;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Per-cycle ALU drive recorded between accept and result_valid
   logic [4:0] ctrl_seq [8];
   logic [7:0] a_seq    [8];
   logic [7:0] b_seq    [8];

   // Offer a command, wait for accept, then count cycles until result_valid
   task automatic issue(input logic [2:0] op, input logic [7:0] opnd, output int lat);
      int t;
      cmd_valid   = 1'b1;
      cmd_op      = op;
      cmd_operand = opnd;
      t = 0;
      while (!cmd_ready && t < 50) begin
         @(posedge clk); #1; t++;
      end
      chk("accept_timeout", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      lat = 1;
      while (!result_valid && lat < 20) begin
         if (lat < 8) begin
            ctrl_seq[lat] = alu_ctrl;
            a_seq[lat]    = alu_a;
            b_seq[lat]    = alu_b;
         end
         @(posedge clk); #1; lat++;
      end
   endtask

   task automatic complete();
      result_ready = 1'b1;
      @(posedge clk); #1;
      result_ready = 1'b0;
   endtask

   typedef struct {
      logic [2:0] op;
      logic [7:0] opnd;
      logic [7:0] d;
      logic       n, z, v;
      int         lat;
   } vec_t;

   localparam int NV = 20;
   vec_t vt [NV];

   initial begin
      int lat;
      vt[0]  = '{3'd0, 8'h64, 8'h64, 1'b0, 1'b0, 1'b0, 2}; // LDA 64
      vt[1]  = '{3'd1, 8'h0B, 8'h6F, 1'b0, 1'b0, 1'b0, 2}; // ADD 0B
      vt[2]  = '{3'd0, 8'h46, 8'h46, 1'b0, 1'b0, 1'b0, 2}; // LDA 46
      vt[3]  = '{3'd1, 8'h3C, 8'h82, 1'b1, 1'b0, 1'b1, 2}; // ADD 3C overflow
      vt[4]  = '{3'd3, 8'h00, 8'h82, 1'b1, 1'b0, 1'b1, 2}; // ORA keeps V
      vt[5]  = '{3'd7, 8'h00, 8'h82, 1'b1, 1'b0, 1'b0, 1}; // CLV
      vt[6]  = '{3'd0, 8'h63, 8'h63, 1'b0, 1'b0, 1'b0, 2}; // LDA 63
      vt[7]  = '{3'd2, 8'h58, 8'h0B, 1'b0, 1'b0, 1'b0, 4}; // SUB 58
      vt[8]  = '{3'd0, 8'h75, 8'h75, 1'b0, 1'b0, 1'b0, 2}; // LDA 75
      vt[9]  = '{3'd5, 8'hE4, 8'h64, 1'b0, 1'b0, 1'b0, 2}; // AND E4
      vt[10] = '{3'd6, 8'h04, 8'h06, 1'b0, 1'b0, 1'b0, 2}; // LSR 4
      vt[11] = '{3'd0, 8'hAA, 8'hAA, 1'b1, 1'b0, 1'b0, 2}; // LDA AA
      vt[12] = '{3'd5, 8'h55, 8'h00, 1'b0, 1'b1, 1'b0, 2}; // AND 55 -> Z
      vt[13] = '{3'd4, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 2}; // EOR FF
      vt[14] = '{3'd6, 8'h09, 8'h00, 1'b0, 1'b1, 1'b0, 2}; // LSR 9 -> 0
      vt[15] = '{3'd0, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 2}; // LDA 80
      vt[16] = '{3'd2, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1, 4}; // SUB 80 overflow
      vt[17] = '{3'd2, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0, 4}; // SUB 01 wrap
      vt[18] = '{3'd1, 8'h7F, 8'h7E, 1'b0, 1'b0, 1'b0, 2}; // ADD 7F wrap
      vt[19] = '{3'd6, 8'h00, 8'h7E, 1'b0, 1'b0, 1'b0, 2}; // LSR 0

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_operand = 8'h00;
      result_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("rst_result_valid", {31'd0, result_valid}, 32'd0);
      chk("rst_alu_ctrl", {27'd0, alu_ctrl}, 32'd0);
      chk("rst_acc", {24'd0, result_data}, 32'd0);
      chk("rst_flags", {29'd0, flag_n, flag_z, flag_v}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

      // Vector table: accumulator carries from one entry to the next
      for (int i = 0; i < NV; i++) begin
         issue(vt[i].op, vt[i].opnd, lat);
         chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
         chk($sformatf("v%0d_data", i), {24'd0, result_data}, {24'd0, vt[i].d});
         chk($sformatf("v%0d_nzv", i), {29'd0, flag_n, flag_z, flag_v},
             {29'd0, vt[i].n, vt[i].z, vt[i].v});
         chk($sformatf("v%0d_busy", i), {31'd0, cmd_ready}, 32'd0);
         if (i == 7) begin
            chk("sub_neg_ctrl", {27'd0, ctrl_seq[1]}, 32'h04);
            chk("sub_neg_a", {24'd0, a_seq[1]}, 32'h58);
            chk("sub_neg_b", {24'd0, b_seq[1]}, 32'hFF);
            chk("sub_inc_ctrl", {27'd0, ctrl_seq[2]}, 32'h10);
            chk("sub_inc_b", {24'd0, b_seq[2]}, 32'h01);
            chk("sub_exec_ctrl", {27'd0, ctrl_seq[3]}, 32'h10);
            chk("sub_exec_a", {24'd0, a_seq[3]}, 32'h63);
            chk("sub_exec_b", {24'd0, b_seq[3]}, 32'hA8);
         end
         if (i == 10) begin
            chk("lsr_exec_ctrl", {27'd0, ctrl_seq[1]}, 32'h01);
         end
         complete();
         chk($sformatf("v%0d_idle", i), {31'd0, cmd_ready}, 32'd1);
         chk($sformatf("v%0d_idle_ctrl", i), {27'd0, alu_ctrl}, 32'd0);
      end

      // Backpressure: response held, stray command ignored
      issue(3'd0, 8'h5A, lat);
      chk("bp_latency", lat, 2);
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", {31'd0, result_valid}, 32'd1);
         chk("bp_data", {24'd0, result_data}, 32'h5A);
         chk("bp_ready", {31'd0, cmd_ready}, 32'd0);
         if (k == 2) begin
            cmd_valid = 1'b1; cmd_op = 3'd1; cmd_operand = 8'h01;
         end else begin
            cmd_valid = 1'b0;
         end
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      complete();
      chk("bp_done_valid", {31'd0, result_valid}, 32'd0);
      chk("bp_done_ready", {31'd0, cmd_ready}, 32'd1);
      chk("bp_acc_kept", {24'd0, result_data}, 32'h5A);
      repeat (2) @(posedge clk);
      #1;
      chk("bp_no_late_resp", {31'd0, result_valid}, 32'd0);

      // Reset during INC of a SUB aborts the command
      issue(3'd0, 8'h10, lat);
      complete();
      cmd_valid = 1'b1; cmd_op = 3'd2; cmd_operand = 8'h01;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      chk("abort_in_inc", {27'd0, alu_ctrl}, 32'h10);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("abort_rst_valid", {31'd0, result_valid}, 32'd0);
      chk("abort_rst_ready", {31'd0, cmd_ready}, 32'd0);
      chk("abort_rst_ctrl", {27'd0, alu_ctrl}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
      chk("abort_acc", {24'd0, result_data}, 32'd0);
      chk("abort_flags", {29'd0, flag_n, flag_z, flag_v}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         chk("abort_no_resp", {31'd0, result_valid}, 32'd0);
         @(posedge clk); #1;
      end

      // Reset wins over a handshake on the same edge
      issue(3'd0, 8'h33, lat);
      complete();
      cmd_valid = 1'b1; cmd_op = 3'd0; cmd_operand = 8'h44;
      rst_n = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      rst_n = 1'b1;
      chk("prio_acc", {24'd0, result_data}, 32'd0);
      chk("prio_ready_low", {31'd0, cmd_ready}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("prio_no_resp", {31'd0, result_valid}, 32'd0);
      end
      chk("prio_ready", {31'd0, cmd_ready}, 32'd1);
      chk("prio_acc_after", {24'd0, result_data}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
